// File: rtl/cc_uart_engine.sv
// cc_uart_engine: UART transmitter and receiver with a first-word
// fall-through RX FIFO. Bit timing comes from down-counters that reload
// with a per-bit cycle count and act when they reach zero.
//
//   state  | meaning
//   IDLE   | TX: waiting for tx_valid   / RX: waiting for a falling edge
//   START  | TX: driving start bit      / RX: waiting for start-bit mid-point
//   DATA   | TX: shifting data LSB first/ RX: sampling data LSB first
//   PARITY | TX: driving parity bit     / RX: sampling parity bit
//   STOP   | TX: driving stop bit       / RX: waiting for stop-bit sample
module cc_uart_engine #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_in,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        rx_done,
    output logic                        rx_parity_err,
    output logic                        rx_frame_err,
    output logic                        rx_overflow,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx_out,
    output logic                        tx_busy,
    output logic                        tx_done
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_W);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
    localparam logic            PAR_EN   = (PARITY_EN != 0);
    localparam logic            PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t            tx_state_q;
    logic [CW-1:0]     tx_cnt_q;
    logic [BW-1:0]     tx_bit_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic              tx_par_q;
    logic              tx_out_q;
    logic              tx_ready_q;
    logic              tx_done_q;

    // TX state machine: every output is a register so tx_out is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        tx_shift_q <= tx_data;
                        tx_par_q   <= (^tx_data) ^ PAR_ODD;
                        tx_cnt_q   <= CNT_BIT;
                        tx_out_q   <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_state_q <= START;
                    end
                end
                START: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q   <= CNT_BIT;
                        tx_out_q   <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= BIT_LAST;
                        tx_state_q <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= CNT_BIT;
                        if (tx_bit_q == '0) begin
                            if (PAR_EN) begin
                                tx_out_q   <= tx_par_q;
                                tx_state_q <= PARITY;
                            end else begin
                                tx_out_q   <= 1'b1;
                                tx_state_q <= STOP;
                            end
                        end else begin
                            tx_out_q   <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_bit_q   <= tx_bit_q - 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                PARITY: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q   <= CNT_BIT;
                        tx_out_q   <= 1'b1;
                        tx_state_q <= STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt_q == '0) begin
                        tx_ready_q <= 1'b1;
                        tx_done_q  <= 1'b1;
                        tx_state_q <= IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end
                end
                default: begin
                    tx_out_q   <= 1'b1;
                    tx_ready_q <= 1'b1;
                    tx_state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = ~tx_ready_q;
    assign tx_done  = tx_done_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_sync1_q;
    logic rx_sync2_q;
    logic rx_prev_q;
    logic rx_s;
    logic rx_fall;

    // Two-flop synchroniser plus one delay flop for falling-edge detection;
    // all reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= rx_in;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    assign rx_s    = rx_sync2_q;
    assign rx_fall = rx_prev_q & ~rx_sync2_q;

    state_t            rx_state_q;
    logic [CW-1:0]     rx_cnt_q;
    logic [BW-1:0]     rx_bit_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic              rx_par_q;
    logic              rx_done_q;
    logic              rx_perr_q;
    logic              rx_ferr_q;
    logic              rx_par_bad;
    logic              rx_stop_hit;
    logic              rx_push;

    assign rx_par_bad  = PAR_EN && (((^rx_shift_q) ^ PAR_ODD) != rx_par_q);
    assign rx_stop_hit = (rx_state_q == STOP) && (rx_cnt_q == '0);
    assign rx_push     = rx_stop_hit && rx_s && !rx_par_bad;

    // RX state machine: mid-bit sampling, status pulses registered at the stop sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            rx_perr_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_state_q)
                IDLE: begin
                    if (rx_fall) begin
                        rx_cnt_q   <= CNT_HALF;
                        rx_state_q <= START;
                    end
                end
                START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_s) begin
                            rx_state_q <= IDLE;
                        end else begin
                            rx_cnt_q   <= CNT_BIT;
                            rx_bit_q   <= BIT_LAST;
                            rx_state_q <= DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_cnt_q   <= CNT_BIT;
                        rx_shift_q <= {rx_s, rx_shift_q[DATA_W-1:1]};
                        if (rx_bit_q == '0) begin
                            rx_state_q <= PAR_EN ? PARITY : STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q - 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                PARITY: begin
                    if (rx_cnt_q == '0) begin
                        rx_par_q   <= rx_s;
                        rx_cnt_q   <= CNT_BIT;
                        rx_state_q <= STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt_q == '0) begin
                        rx_done_q  <= 1'b1;
                        rx_ferr_q  <= ~rx_s;
                        rx_perr_q  <= rx_par_bad;
                        rx_state_q <= IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end
                end
                default: begin
                    rx_state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_done       = rx_done_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

    // ------------------------------------------------------------------
    // RX FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              ovf_q;
    logic              fifo_full;
    logic              fifo_pop;
    logic              fifo_push;
    logic              fifo_drop;

    assign fifo_full = (count_q == FULL_CNT);
    assign fifo_pop  = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    assign fifo_push = rx_push && (!fifo_full || fifo_pop);
    assign fifo_drop = rx_push && fifo_full && !fifo_pop;

    // Next-state pointers and occupancy; pointers wrap naturally at 2**AW.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (fifo_push && !fifo_pop) begin
            count_d = count_q + 1'b1;
        end else if (fifo_pop && !fifo_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO control registers and the overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= fifo_drop;
        end
    end

    // FIFO storage; contents are only meaningful while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= rx_shift_q;
        end
    end

    assign rx_data     = fifo_mem[rd_ptr_q];
    assign rx_valid    = (count_q != '0);
    assign rx_count    = count_q;
    assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_cc_uart_engine.sv
// Bench for cc_uart_engine: one instance without parity for TX waveform and
// reset checks, one with even parity for loopback and receiver/FIFO checks.
module tb_cc_uart_engine;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // no-parity instance
    logic          np_rx_in    = 1'b1;
    logic          np_rx_ready = 1'b0;
    logic [DW-1:0] np_tx_data  = '0;
    logic          np_tx_valid = 1'b0;
    logic [DW-1:0] np_rx_data;
    logic          np_rx_valid, np_rx_done, np_rx_perr, np_rx_ferr, np_rx_ovf;
    logic [2:0]    np_rx_count;
    logic          np_tx_ready, np_tx_out, np_tx_busy, np_tx_done;

    // even-parity instance
    logic          rx_drv     = 1'b1;
    logic          loop_sel   = 1'b0;
    logic          p_rx_in;
    logic          p_rx_ready = 1'b0;
    logic [DW-1:0] p_tx_data  = '0;
    logic          p_tx_valid = 1'b0;
    logic [DW-1:0] p_rx_data;
    logic          p_rx_valid, p_rx_done, p_rx_perr, p_rx_ferr, p_rx_ovf;
    logic [2:0]    p_rx_count;
    logic          p_tx_ready, p_tx_out, p_tx_busy, p_tx_done;

    assign p_rx_in = loop_sel ? p_tx_out : rx_drv;

    cc_uart_engine #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut_np (
        .clk(clk), .rst(rst), .rx_in(np_rx_in), .rx_data(np_rx_data), .rx_valid(np_rx_valid),
        .rx_ready(np_rx_ready), .rx_count(np_rx_count), .rx_done(np_rx_done),
        .rx_parity_err(np_rx_perr), .rx_frame_err(np_rx_ferr), .rx_overflow(np_rx_ovf),
        .tx_data(np_tx_data), .tx_valid(np_tx_valid), .tx_ready(np_tx_ready),
        .tx_out(np_tx_out), .tx_busy(np_tx_busy), .tx_done(np_tx_done));

    cc_uart_engine #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut_p (
        .clk(clk), .rst(rst), .rx_in(p_rx_in), .rx_data(p_rx_data), .rx_valid(p_rx_valid),
        .rx_ready(p_rx_ready), .rx_count(p_rx_count), .rx_done(p_rx_done),
        .rx_parity_err(p_rx_perr), .rx_frame_err(p_rx_ferr), .rx_overflow(p_rx_ovf),
        .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready),
        .tx_out(p_tx_out), .tx_busy(p_tx_busy), .tx_done(p_tx_done));

    // Pulse counters, sampled mid-cycle.
    int n_np_txdone = 0, n_done = 0, n_perr = 0, n_ferr = 0, n_ovf = 0, n_fe_both = 0;
    always @(negedge clk) begin
        if (np_tx_done) n_np_txdone++;
        if (p_rx_done) n_done++;
        if (p_rx_perr) n_perr++;
        if (p_rx_ferr) n_ferr++;
        if (p_rx_ovf) n_ovf++;
        if (p_rx_done && p_rx_ferr) n_fe_both++;
    end

    // Reference model of the RX FIFO contents.
    logic [DW-1:0] q [$];

    typedef struct {
        logic [DW-1:0] data;
        bit            bad_par;
        bit            bad_stop;
        bit            e_perr;
        bit            e_ferr;
        bit            e_good;
    } rxvec_t;
    rxvec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one serial frame (even parity) on the parity instance's RX line.
    task automatic send_rx(input logic [DW-1:0] d, input bit bad_par, input bit bad_stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < DW; k++) begin
            rx_drv = d[k];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = (^d) ^ bad_par;
        repeat (CPB) @(negedge clk);
        rx_drv = ~bad_stop;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic rx_check(input string name, input logic [DW-1:0] d, input bit bp, input bit bs,
                            input bit e_perr, input bit e_ferr, input bit e_good);
        int d0, p0, f0, o0, b0;
        bit e_ovf;
        d0 = n_done; p0 = n_perr; f0 = n_ferr; o0 = n_ovf; b0 = n_fe_both;
        e_ovf = e_good && (q.size() == DEPTH);
        if (e_good && !e_ovf) q.push_back(d);
        send_rx(d, bp, bs);
        chk({name, "_done"}, n_done - d0, 1);
        chk({name, "_perr"}, n_perr - p0, e_perr);
        chk({name, "_ferr"}, n_ferr - f0, e_ferr);
        chk({name, "_ferr_with_done"}, n_fe_both - b0, e_ferr);
        chk({name, "_ovf"}, n_ovf - o0, e_ovf);
        chk({name, "_count"}, p_rx_count, q.size());
    endtask

    task automatic pop_check(input string name, input logic [DW-1:0] exp);
        logic [DW-1:0] dummy;
        @(negedge clk);
        chk({name, "_valid"}, p_rx_valid, 1);
        chk({name, "_data"}, p_rx_data, exp);
        p_rx_ready = 1'b1;
        @(negedge clk);
        p_rx_ready = 1'b0;
        if (q.size() > 0) dummy = q.pop_front();
        chk({name, "_count"}, p_rx_count, q.size());
    endtask

    task automatic drain();
        while (q.size() > 0) pop_check("drain", q[0]);
    endtask

    task automatic wait_np_ready();
        for (int k = 0; k < 200 && !np_tx_ready; k++) @(negedge clk);
        chk("np_tx_ready_wait", np_tx_ready, 1);
    endtask

    initial begin
        logic [DW-1:0] txd [5];
        logic [9:0]    bits;
        logic [DW-1:0] rd;
        int            k, s0;
        bit            bp, bs;

        vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[4] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[5] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state, observed while rst is held high.
        repeat (3) @(negedge clk);
        chk("rst_tx_out", np_tx_out, 1);
        chk("rst_tx_ready", np_tx_ready, 1);
        chk("rst_tx_busy", np_tx_busy, 0);
        chk("rst_tx_done", np_tx_done, 0);
        chk("rst_rx_valid", p_rx_valid, 0);
        chk("rst_rx_count", p_rx_count, 0);
        chk("rst_rx_done", p_rx_done, 0);
        chk("rst_rx_ovf", p_rx_ovf, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // TX: 0xA5 first, then random bytes back-to-back; tx_valid stays high
        // with junk data during frames, which must be ignored.
        txd[0] = 8'hA5;
        for (int f = 1; f < 5; f++) txd[f] = 8'($urandom);
        wait_np_ready();
        np_tx_data  = txd[0];
        np_tx_valid = 1'b1;
        for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            np_tx_data = 8'($urandom);
            bits = {1'b1, txd[f], 1'b0};
            for (int i = 0; i < 40; i++) begin
                chk($sformatf("tx_f%0d_c%0d_out", f, i), np_tx_out, bits[i / CPB]);
                if (i == 20) begin
                    chk("tx_mid_busy", np_tx_busy, 1);
                    chk("tx_mid_ready", np_tx_ready, 0);
                    chk("tx_mid_done", np_tx_done, 0);
                end
                @(negedge clk);
            end
            chk($sformatf("tx_f%0d_done_at_40", f), np_tx_done, 1);
            chk($sformatf("tx_f%0d_ready_at_40", f), np_tx_ready, 1);
            if (f < 4) np_tx_data = txd[f + 1];
            else np_tx_valid = 1'b0;
        end
        @(negedge clk);
        chk("tx_done_single", np_tx_done, 0);
        chk("tx_idle_out", np_tx_out, 1);
        chk("tx_idle_ready", np_tx_ready, 1);

        // Loopback with even parity.
        loop_sel = 1'b1;
        wait (p_tx_ready);
        @(negedge clk);
        p_tx_data  = 8'h3C;
        p_tx_valid = 1'b1;
        @(negedge clk);
        p_tx_valid = 1'b0;
        k = 0;
        while (!p_rx_done && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("loop_rx_done", p_rx_done, 1);
        chk("loop_rx_data", p_rx_data, 8'h3C);
        chk("loop_rx_valid", p_rx_valid, 1);
        chk("loop_rx_count", p_rx_count, 1);
        chk("loop_perr", p_rx_perr, 0);
        chk("loop_ferr", p_rx_ferr, 0);
        q.push_back(8'h3C);
        repeat (20) @(negedge clk);
        loop_sel = 1'b0;
        drain();

        // Popping an empty FIFO has no effect.
        @(negedge clk);
        p_rx_ready = 1'b1;
        @(negedge clk);
        p_rx_ready = 1'b0;
        chk("empty_pop_count", p_rx_count, 0);
        chk("empty_pop_valid", p_rx_valid, 0);

        // Table-driven receive vectors.
        for (int v = 0; v < 6; v++)
            rx_check($sformatf("vec%0d", v), vt[v].data, vt[v].bad_par, vt[v].bad_stop,
                     vt[v].e_perr, vt[v].e_ferr, vt[v].e_good);
        drain();

        // Two-cycle glitch is a false start.
        s0 = n_done;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_no_done", n_done - s0, 0);
        chk("glitch_count", p_rx_count, 0);

        // Overflow: five bytes into a four-entry FIFO.
        for (int b = 1; b <= 5; b++)
            rx_check($sformatf("ovf_b%0d", b), 8'(b), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int b = 1; b <= 4; b++) pop_check($sformatf("ovf_pop%0d", b), 8'(b));
        chk("ovf_empty", p_rx_valid, 0);

        // Randomised receive traffic against the queue model.
        for (int r = 0; r < 24; r++) begin
            rd = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 5) == 0);
            rx_check($sformatf("rnd%0d", r), rd, bp, bs, bp, bs, !bp && !bs);
            k = $urandom_range(0, 2);
            for (int p = 0; p < k && q.size() > 0; p++) pop_check($sformatf("rnd%0d_pop", r), q[0]);
        end
        drain();

        // Reset mid-frame on both transmitter and receiver.
        rx_check("pre_rst", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_np_ready();
        np_tx_data  = 8'($urandom);
        np_tx_valid = 1'b1;
        @(negedge clk);
        np_tx_valid = 1'b0;
        rx_drv = 1'b0;
        repeat (15) @(negedge clk);
        rx_drv = 1'b1;
        s0 = n_np_txdone;
        k  = n_done + n_perr + n_ferr + n_ovf;
        rst = 1'b1;
        #1;
        chk("midrst_tx_out", np_tx_out, 1);
        chk("midrst_tx_ready", np_tx_ready, 1);
        chk("midrst_tx_busy", np_tx_busy, 0);
        chk("midrst_rx_count", p_rx_count, 0);
        chk("midrst_rx_valid", p_rx_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        repeat (80) @(negedge clk);
        chk("midrst_no_tx_done", n_np_txdone - s0, 0);
        chk("midrst_no_rx_pulses", n_done + n_perr + n_ferr + n_ovf - k, 0);
        chk("midrst_tx_out_idle", np_tx_out, 1);
        chk("midrst_rx_count_after", p_rx_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/cc_uart_engine.md
CC_UART_ENGINE -- requirements
Module: cc_uart_engine

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning data bits per frame (legal range 5-8).
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 16, meaning clk cycles per bit (minimum 4).
REQ-003 SHALL provide parameter PARITY_EN, default 0, meaning 1 inserts and checks one parity bit after the data bits.
REQ-004 SHALL provide parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity.
REQ-005 SHALL provide parameter FIFO_DEPTH, default 4, meaning RX FIFO entries (power of 2, at least 2).
REQ-006 SHALL provide ports as follows:
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  rx_in  in  1  serial RX line, asynchronous, idles high.
  rx_data  out  DATA_W  head of the RX FIFO.
  rx_valid  out  1  RX FIFO not empty.
  rx_ready  in  1  pops the FIFO when rx_valid is also high.
  rx_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
  rx_done  out  1  one-cycle pulse when any frame ends.
  rx_parity_err  out  1  one-cycle pulse on parity mismatch.
  rx_frame_err  out  1  one-cycle pulse when the stop bit samples low.
  rx_overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
  tx_data  in  DATA_W  byte to transmit.
  tx_valid  in  1  transmit request.
  tx_ready  out  1  transmitter idle and able to accept.
  tx_out  out  1  serial TX line, idles high.
  tx_busy  out  1  equals NOT tx_ready.
  tx_done  out  1  one-cycle pulse at the end of a frame.

Function
REQ-007 SHALL implement a TX state machine with states IDLE, START, DATA, PARITY and STOP; the PARITY state is skipped when PARITY_EN=0.
REQ-008 SHALL accept a TX byte when tx_valid and tx_ready are both high, latch tx_data, and enter START on the next edge.
REQ-009 SHALL drive tx_ready high only in IDLE and ignore tx_valid in every other state.
REQ-010 SHALL hold each TX bit on tx_out for exactly CLKS_PER_BIT cycles: start bit low, then data bits LSB first, then parity if enabled, then one stop bit high.
REQ-011 SHALL compute parity as XOR of the data bits, inverted when PARITY_ODD=1.
REQ-012 SHALL pulse tx_done for the single cycle in which STOP returns to IDLE; tx_ready SHALL go high in that same cycle.
REQ-013 SHALL support back-to-back TX frames: a byte accepted in the tx_done cycle starts its start bit on the next cycle.
REQ-014 SHALL pass rx_in through a 2-flop synchroniser whose flops reset to 1; all RX timing is measured from the synchroniser output.
REQ-015 SHALL implement an RX state machine with states IDLE, START, DATA, PARITY and STOP.
REQ-016 SHALL leave IDLE on a synchronised high-to-low transition and sample the start bit CLKS_PER_BIT/2 cycles later; a high sample is a false start and returns the machine to IDLE with no pulses.
REQ-017 SHALL sample each subsequent bit every CLKS_PER_BIT cycles after the start-bit mid-point, assembling data LSB first.
REQ-018 SHALL evaluate the frame at the stop-bit sample and then return to IDLE; a new falling edge is detected from the following cycle.
REQ-019 SHALL pulse rx_done at the stop-bit sample for every frame that passes the start-bit check.
REQ-020 SHALL pulse rx_frame_err when the stop bit samples low, and discard the byte.
REQ-021 SHALL pulse rx_parity_err on a parity mismatch, and discard the byte; when both errors occur, both pulse and the byte is discarded.
REQ-022 SHALL push an error-free byte into the FIFO in the stop-sample cycle.
REQ-023 SHALL make the FIFO first-word fall-through: rx_data shows the oldest entry whenever rx_valid is high, and rx_data is don't-care when the FIFO is empty.
REQ-024 SHALL pop the FIFO when rx_valid and rx_ready are both high; rx_ready while the FIFO is empty has no effect.
REQ-025 SHALL, on a push while full, accept the push if a pop occurs in the same cycle (count unchanged); otherwise it drops the new byte, pulses rx_overflow and leaves the contents intact.
REQ-026 SHALL, on a simultaneous push and pop while non-full and non-empty, leave the count unchanged.
REQ-027 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, while rst is high, force both state machines to IDLE, empty the FIFO, and clear every pulse output, rx_valid and rx_count; it SHALL drive tx_out=1, tx_ready=1 and tx_busy=0.
REQ-029 SHALL, on reset mid-frame, abandon the frame without emitting tx_done, rx_done or any error pulse.

Verification
REQ-030 SHALL, with CLKS_PER_BIT=4, DATA_W=8 and PARITY_EN=0, transmit tx_data=0xA5 -> tx_out reads 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit, and tx_done pulses 40 cycles after acceptance.
REQ-031 SHALL loop tx_out to rx_in with even parity and send 0x3C -> rx_data=0x3C, rx_valid=1 and rx_count=1, with no error pulses.
REQ-032 SHALL drive a frame with a low stop bit -> rx_frame_err and rx_done pulse together and rx_count stays 0.
REQ-033 SHALL, with FIFO_DEPTH=4 and rx_ready=0, receive 5 bytes 0x01-0x05 -> rx_overflow pulses on the 5th byte only, then pops yield 0x01-0x04 in order.
REQ-034 SHALL apply a 2-cycle low glitch on rx_in -> false start, no rx_done, and rx_count unchanged.
REQ-035 SHALL assert rst midway through a TX frame -> tx_out=1 and tx_ready=1 immediately, and no tx_done.
